ysyx_24080006_icache_assoc: RTL and testbench

Parametrised N-way set-associative instruction cache, the successor to the direct-mapped `icache_t` organisation. Sits between IFU and the AXI4 read master of the core. It serves 32-bit fetches from a tag/data array, refills whole lines with an INCR burst on a miss, and supports whole-cache invalidation for FENCE.I.

---
 rtl/ysyx_24080006_icache_assoc_pkg.sv | 26 ++
 rtl/ysyx_24080006_icache_array.sv | 81 ++++++++
 rtl/ysyx_24080006_icache_assoc.sv | 173 +++++++++++++++++
 tb/tb_ysyx_24080006_icache_assoc.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24080006_icache_assoc_pkg.sv
// Shared geometry defaults, FSM encoding and AXI constants for the set-associative I-cache.
package ysyx_24080006_icache_assoc_pkg;

  localparam int unsigned IC_M    = 4;
  localparam int unsigned IC_N    = 2;
  localparam int unsigned IC_WAYS = 2;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StAr,
    StR,
    StResp
  } icache_state_e;

  // One way's entry at the default geometry.
  typedef struct packed {
    logic                  valid;
    logic [31-IC_M-IC_N:0] tag;
    logic [(8<<IC_M)-1:0]  line;
  } icache_t;

endpackage

// File: rtl/ysyx_24080006_icache_array.sv
// Valid/tag/line storage for every way plus per-set round-robin victim pointers.
// Parallel lookup yields a one-hot hit vector; refills pick their own victim way.
module ysyx_24080006_icache_array #(
  parameter int unsigned IC_M    = 4,
  parameter int unsigned IC_N    = 2,
  parameter int unsigned IC_WAYS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [IC_N-1:0]       rd_idx_i,
  input  logic [31-IC_M-IC_N:0] rd_tag_i,
  output logic [IC_WAYS-1:0]    hit_o,
  output logic [(8<<IC_M)-1:0]  hit_line_o,
  input  logic                  we_i,
  input  logic [IC_N-1:0]       wr_idx_i,
  input  logic [31-IC_M-IC_N:0] wr_tag_i,
  input  logic [(8<<IC_M)-1:0]  wr_line_i,
  input  logic                  inv_i
);
  localparam int unsigned Sets  = 1 << IC_N;
  localparam int unsigned TagW  = 32 - IC_M - IC_N;
  localparam int unsigned LineW = 8 << IC_M;
  localparam int unsigned PtrW  = (IC_WAYS > 1) ? $clog2(IC_WAYS) : 1;

  logic [IC_WAYS-1:0] valid_q [Sets];
  logic [PtrW-1:0]    ptr_q   [Sets];
  logic [TagW-1:0]    tag_q   [Sets][IC_WAYS];
  logic [LineW-1:0]   line_q  [Sets][IC_WAYS];

  logic [PtrW-1:0] victim;
  logic            has_free;

  always_comb begin
    hit_o      = '0;
    hit_line_o = '0;
    for (int w = 0; w < IC_WAYS; w++) begin
      hit_o[w] = valid_q[rd_idx_i][w] && (tag_q[rd_idx_i][w] == rd_tag_i);
      if (hit_o[w]) hit_line_o = hit_line_o | line_q[rd_idx_i][w];
    end
  end

  // Scan downwards so the lowest-numbered invalid way wins over the pointer.
  always_comb begin
    victim   = ptr_q[wr_idx_i];
    has_free = 1'b0;
    for (int w = IC_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[wr_idx_i][w]) begin
        victim   = PtrW'(w);
        has_free = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < Sets; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (inv_i) begin
      for (int s = 0; s < Sets; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (we_i) begin
      valid_q[wr_idx_i][victim] <= 1'b1;
      if (!has_free) begin
        ptr_q[wr_idx_i] <= (ptr_q[wr_idx_i] == PtrW'(IC_WAYS - 1)) ? '0
                                                                  : ptr_q[wr_idx_i] + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (we_i) begin
      tag_q[wr_idx_i][victim]  <= wr_tag_i;
      line_q[wr_idx_i][victim] <= wr_line_i;
    end
  end

endmodule

// File: rtl/ysyx_24080006_icache_assoc.sv
// N-way set-associative instruction cache with AXI4 INCR line refill and FENCE.I flush.
// Define ICACHE_PERF_EN to add the perf_hit / perf_miss counters.
module ysyx_24080006_icache_assoc #(
  parameter int unsigned IC_M    = ysyx_24080006_icache_assoc_pkg::IC_M,
  parameter int unsigned IC_N    = ysyx_24080006_icache_assoc_pkg::IC_N,
  parameter int unsigned IC_WAYS = ysyx_24080006_icache_assoc_pkg::IC_WAYS
) (
`ifdef ICACHE_PERF_EN
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss,
`endif
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_rsp_valid,
  input  logic        ifu_rsp_ready,
  output logic [31:0] ifu_rsp_data,
  output logic        ifu_rsp_err,
  input  logic        fence_i,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast
);
  import ysyx_24080006_icache_assoc_pkg::*;

  localparam int unsigned Beats = 1 << (IC_M - 2);
  localparam int unsigned BeatW = IC_M - 2;
  localparam int unsigned LineW = 8 << IC_M;

  icache_state_e     state_q;
  logic [31:2]       addr_q;
  logic [31:0]       araddr_q;
  logic [BeatW-1:0]  cnt_q;
  logic              err_q;
  logic              pend_q;
  logic [31:0]       buf_q [Beats];

  logic [IC_WAYS-1:0] hit_vec;
  logic [LineW-1:0]   hit_line;
  logic [LineW-1:0]   fill_line;
  logic               hit, inv, beat_err, we, lookup_rsp;
  logic [BeatW-1:0]   word;
  logic               unused_addr;

  assign unused_addr = ^ifu_req_addr[1:0];
  assign word        = addr_q[IC_M-1:2];
  assign hit         = |hit_vec;
  // A pending flush is applied in the first IDLE cycle and blocks acceptance there.
  assign inv         = (state_q == StIdle) && (fence_i || pend_q);
  assign beat_err    = (rresp != 2'b00);
  assign we          = (state_q == StR) && rvalid && rlast && !err_q && !beat_err;
  assign lookup_rsp  = (state_q == StLookup) && hit;

  // The last beat is still on rdata when the line is installed.
  always_comb begin
    fill_line = '0;
    for (int b = 0; b < Beats; b++) begin
      fill_line[b*32 +: 32] = (BeatW'(b) == cnt_q) ? rdata : buf_q[b];
    end
  end

  ysyx_24080006_icache_array #(
    .IC_M   (IC_M),
    .IC_N   (IC_N),
    .IC_WAYS(IC_WAYS)
  ) u_array (
    .clock     (clock),
    .reset     (reset),
    .rd_idx_i  (addr_q[IC_M+IC_N-1:IC_M]),
    .rd_tag_i  (addr_q[31:IC_M+IC_N]),
    .hit_o     (hit_vec),
    .hit_line_o(hit_line),
    .we_i      (we),
    .wr_idx_i  (addr_q[IC_M+IC_N-1:IC_M]),
    .wr_tag_i  (addr_q[31:IC_M+IC_N]),
    .wr_line_i (fill_line),
    .inv_i     (inv)
  );

  assign ifu_req_ready = (state_q == StIdle) && !inv;
  assign ifu_rsp_valid = lookup_rsp || (state_q == StResp);
  assign ifu_rsp_err   = (state_q == StResp) && err_q;
  assign ifu_rsp_data  = lookup_rsp           ? hit_line[word*32 +: 32] :
                         (state_q == StResp)  ? buf_q[word]             : '0;
  assign arvalid       = (state_q == StAr);
  assign araddr        = araddr_q;
  assign arlen         = 8'(Beats - 1);
  assign arsize        = AXI_SIZE_4B;
  assign arburst       = AXI_BURST_INCR;
  assign rready        = (state_q == StR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      araddr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      if ((state_q != StIdle) && fence_i) pend_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (inv) begin
            pend_q <= 1'b0;
          end else if (ifu_req_valid) begin
            addr_q  <= ifu_req_addr[31:2];
            state_q <= StLookup;
          end
        end
        StLookup: begin
          if (hit) begin
            if (ifu_rsp_ready) state_q <= StIdle;
          end else begin
            araddr_q <= {addr_q[31:IC_M], {IC_M{1'b0}}};
            cnt_q    <= '0;
            err_q    <= 1'b0;
            state_q  <= StAr;
          end
        end
        StAr: begin
          if (arready) state_q <= StR;
        end
        StR: begin
          if (rvalid) begin
            cnt_q <= cnt_q + BeatW'(1);
            if (beat_err) err_q <= 1'b1;
            if (rlast) state_q <= StResp;
          end
        end
        StResp: begin
          if (ifu_rsp_ready) begin
            err_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if ((state_q == StR) && rvalid) buf_q[cnt_q] <= rdata;
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit_q, perf_miss_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else begin
      if (lookup_rsp && ifu_rsp_ready) perf_hit_q <= perf_hit_q + 32'd1;
      if ((state_q == StLookup) && !hit) perf_miss_q <= perf_miss_q + 32'd1;
    end
  end

  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;
`endif

endmodule

// File: tb/tb_ysyx_24080006_icache_assoc.sv
// Scoreboard bench for the set-associative I-cache: directed fetches, AXI slave model, checker.
module tb_ysyx_24080006_icache_assoc;

  logic        clock = 1'b0;
  logic        reset;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [31:0] ifu_rsp_data;
  logic        fence_i;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit, perf_miss;
`endif

  always #5 clock = ~clock;

  ysyx_24080006_icache_assoc dut (
`ifdef ICACHE_PERF_EN
    .perf_hit     (perf_hit),
    .perf_miss    (perf_miss),
`endif
    .clock        (clock),
    .reset        (reset),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr (ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_data (ifu_rsp_data),
    .ifu_rsp_err  (ifu_rsp_err),
    .fence_i      (fence_i),
    .arvalid      (arvalid),
    .arready      (arready),
    .araddr       (araddr),
    .arlen        (arlen),
    .arsize       (arsize),
    .arburst      (arburst),
    .rvalid       (rvalid),
    .rready       (rready),
    .rdata        (rdata),
    .rresp        (rresp),
    .rlast        (rlast)
  );

  typedef struct packed {
    logic [1:0]  r;
    logic [31:0] d;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] ar_q[$];
  logic [32:0] rsp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          ar_count = 0;
  int          exp_ar = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_line(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3, input int err_beat);
    logic [31:0] d [4];
    d = '{d0, d1, d2, d3};
    ar_q.push_back(a);
    exp_ar++;
    for (int i = 0; i < 4; i++) beat_q.push_back({(err_beat == i) ? 2'b10 : 2'b00, d[i]});
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (k < 50) begin
      @(negedge clock);
      if (ifu_req_ready) break;
      k++;
    end
    if (k >= 50) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_accept: got req_ready 0, want 1 within 50 cycles", name);
    end
    @(posedge clock);
    #1;
    ifu_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int k = 0;
    while (k < 200) begin
      @(negedge clock);
      if (ifu_rsp_valid && ifu_rsp_ready) break;
      k++;
    end
    if (k >= 200) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_rsp: got no response, want one within 200 cycles", name);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] d,
                       input logic e, input bit hit);
    rsp_q.push_back({e, d});
    ifu_req_valid = 1'b1;
    ifu_req_addr  = a;
    wait_req(name);
    if (hit) begin
      @(negedge clock);
      chk({name, "_lat"}, ifu_rsp_valid, 1);
      @(posedge clock);
      #1;
    end else begin
      wait_rsp(name);
    end
    chk({name, "_ar"}, ar_count, exp_ar);
  endtask

  task automatic pulse_in_r();
    int k = 0;
    while (k < 100) begin
      @(negedge clock);
      if (rready) break;
      k++;
    end
    fence_i = 1'b1;
    @(posedge clock);
    #1;
    fence_i = 1'b0;
  endtask

  // Response monitor: pops the scoreboard on each handshake.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clock);
      if (!reset && ifu_rsp_valid && ifu_rsp_ready) begin
        if (rsp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL rsp_unexpected: got data 0x%08h, want no response", ifu_rsp_data);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_data", ifu_rsp_data, e[31:0]);
          chk("rsp_err", ifu_rsp_err, {31'b0, e[32]});
        end
      end
    end
  end

  // AXI read slave: checks each AR against the expected queue, then streams queued beats.
  initial begin
    beat_t b;
    int    k;
    arready = 1'b1;
    rvalid  = 1'b0;
    rdata   = '0;
    rresp   = '0;
    rlast   = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset && arvalid) begin
        ar_count++;
        if (ar_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL ar_unexpected: got araddr 0x%08h, want no AR", araddr);
        end else begin
          chk("araddr", araddr, ar_q.pop_front());
        end
        chk("arlen", {24'b0, arlen}, 32'd3);
        chk("arsize", {29'b0, arsize}, 32'd2);
        chk("arburst", {30'b0, arburst}, 32'd1);
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
          if (beat_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL beat_underflow: got empty beat queue, want beat %0d", i);
            b = '0;
          end else begin
            b = beat_q.pop_front();
          end
          rvalid = 1'b1;
          rdata  = b.d;
          rresp  = b.r;
          rlast  = (i == 3);
          k = 0;
          while (k < 50) begin
            @(negedge clock);
            if (rready) break;
            k++;
          end
          @(posedge clock);
          #1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    ifu_req_valid = 1'b0;
    ifu_req_addr  = '0;
    ifu_rsp_ready = 1'b1;
    fence_i       = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", ifu_req_ready, 1);
    chk("rst_rsp_valid", ifu_rsp_valid, 0);
    chk("rst_rsp_err", ifu_rsp_err, 0);
    chk("rst_rsp_data", ifu_rsp_data, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_araddr", araddr, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Cold miss then hit.
    push_line(32'h8000_0000, 32'h11, 32'h22, 32'h33, 32'h44, -1);
    fetch("cold_miss", 32'h8000_0004, 32'h22, 1'b0, 1'b0);
    fetch("warm_hit", 32'h8000_0008, 32'h33, 1'b0, 1'b1);
`ifdef ICACHE_PERF_EN
    chk("perf_miss", perf_miss, 1);
    chk("perf_hit", perf_hit, 1);
`endif

    // Set 0 conflicts and round-robin eviction.
    push_line(32'h8000_0040, 32'h4040_0000, 32'h4040_0001, 32'h4040_0002, 32'h4040_0003, -1);
    fetch("fill_40", 32'h8000_0040, 32'h4040_0000, 1'b0, 1'b0);
    push_line(32'h8000_0080, 32'h8080_0000, 32'h8080_0001, 32'h8080_0002, 32'h8080_0003, -1);
    fetch("fill_80", 32'h8000_0084, 32'h8080_0001, 1'b0, 1'b0);
    fetch("hit_40", 32'h8000_004C, 32'h4040_0003, 1'b0, 1'b1);
    push_line(32'h8000_0000, 32'h11, 32'h22, 32'h33, 32'h44, -1);
    fetch("evicted_00", 32'h8000_0000, 32'h11, 1'b0, 1'b0);
    fetch("hit_80", 32'h8000_0088, 32'h8080_0002, 1'b0, 1'b1);
    push_line(32'h8000_0040, 32'h4040_0000, 32'h4040_0001, 32'h4040_0002, 32'h4040_0003, -1);
    fetch("evicted_40", 32'h8000_0044, 32'h4040_0001, 1'b0, 1'b0);
    fetch("hit_00", 32'h8000_000C, 32'h44, 1'b0, 1'b1);

    // FENCE.I with a simultaneous request in IDLE: flush wins.
    fence_i       = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_0008;
    @(negedge clock);
    chk("fence_req_ready", ifu_req_ready, 0);
    @(posedge clock);
    #1;
    fence_i       = 1'b0;
    ifu_req_valid = 1'b0;

    // FENCE.I during the refill burst: response completes, flush applied after.
    push_line(32'h8000_0000, 32'h11, 32'h22, 32'h33, 32'h44, -1);
    fork
      fetch("fence_miss", 32'h8000_0008, 32'h33, 1'b0, 1'b0);
      pulse_in_r();
    join
    @(negedge clock);
    chk("pend_ready_lo", ifu_req_ready, 0);
    @(negedge clock);
    chk("pend_ready_hi", ifu_req_ready, 1);
    @(posedge clock);
    #1;
    push_line(32'h8000_0000, 32'h11, 32'h22, 32'h33, 32'h44, -1);
    fetch("post_fence_miss", 32'h8000_0000, 32'h11, 1'b0, 1'b0);
    fetch("post_fence_hit", 32'h8000_0004, 32'h22, 1'b0, 1'b1);

    // Error response on beat 1: flagged, not installed.
    push_line(32'h8000_0010, 32'h51, 32'h52, 32'h53, 32'h54, 1);
    fetch("err_fill", 32'h8000_0014, 32'h52, 1'b1, 1'b0);
    push_line(32'h8000_0010, 32'h51, 32'h52, 32'h53, 32'h54, -1);
    fetch("err_refetch", 32'h8000_0014, 32'h52, 1'b0, 1'b0);
    fetch("err_then_hit", 32'h8000_0018, 32'h53, 1'b0, 1'b1);

    // Backpressure on a hit for five cycles.
    rsp_q.push_back({1'b0, 32'h54});
    ifu_rsp_ready = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_req_addr  = 32'h8000_001C;
    wait_req("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_rsp_valid", ifu_rsp_valid, 1);
      chk("bp_rsp_data", ifu_rsp_data, 32'h54);
      chk("bp_req_ready", ifu_req_ready, 0);
      chk("bp_arvalid", arvalid, 0);
    end
    @(posedge clock);
    #1;
    ifu_rsp_ready = 1'b1;
    wait_rsp("bp");
    chk("bp_ar", ar_count, exp_ar);
    chk("rsp_drained", rsp_q.size(), 0);

    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
